tx_burst_scheduler: RTL and testbench

Multi-channel burst scheduler that feeds the 64-bit user port of `tx_interface`. It arbitrates round-robin between `NUM_CH` requester channels and holds a grant for one burst of up to `BURST_MAX` words. On each `DATA_IN_READY` slot strobe it presents one registered word, or an idle slot, together with channel and burst-delimiting sideband for the framing logic.

---
 rtl/tx_burst_scheduler_pkg.sv | 30 +++
 rtl/tx_burst_scheduler_rr_arbiter.sv | 51 +++++
 rtl/tx_burst_scheduler.sv | 145 ++++++++++++++
 tb/tb_tx_burst_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_burst_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tx_burst_scheduler_pkg
//  Purpose  : Shared definitions for the tx burst scheduler slice: word
//             width, default burst length, channel-index width helper,
//             block-type header codes and the scheduler state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tx_burst_scheduler_pkg;

    localparam int c_WORD_W        = 64;
    localparam int c_BURST_MAX_DEF = 8;

    // Block-type header codes used further down the tx path
    localparam logic [1:0] c_BLK_DATA = 2'b01;
    localparam logic [1:0] c_BLK_CTRL = 2'b10;

    // Width of an encoded channel index
    function automatic int ch_w(input int num_ch);
        return $clog2(num_ch);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_burst_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Picks the first asserted
//             request searching from ptr+1, wrapping at NUM_CH.
//  Ports    : req   - request vector
//             ptr   - index of the previous winner
//             grant - one-hot grant
//             idx   - encoded index of the winner
//             any   - at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import tx_burst_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [ch_w(NUM_CH)-1:0]   ptr,
    output logic [NUM_CH-1:0]         grant,
    output logic [ch_w(NUM_CH)-1:0]   idx,
    output logic                      any
);

    localparam int CH_W = ch_w(NUM_CH);

    always_comb begin
        int                j;
        logic [CH_W-1:0]   w_j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        w_j   = '0;
        // Offset 1 first, so the previous winner has lowest priority
        for (int k = 1; k <= NUM_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            w_j = CH_W'(j);
            if (!any && req[w_j]) begin
                any        = 1'b1;
                idx        = w_j;
                grant[w_j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tx_burst_scheduler
//  Purpose  : Round-robin burst scheduler feeding the 64-bit user port of
//             tx_interface. Locks onto one channel for a burst of up to
//             BURST_MAX words and emits one registered word (or an idle
//             slot) per TX_READY strobe, with burst/packet sideband.
//  Ports    : USER_CLK, SYSTEM_RESET (async, active high)
//             CH_DATA/CH_VALID/CH_EOP/CH_ENABLE - per-channel heads + mask
//             CH_POP      - combinational one-hot head advance
//             TX_READY    - slot strobe
//             TX_DATA/TX_VALID/TX_CHANNEL/TX_SOB/TX_EOB/TX_EOP/TX_ABORT
//                         - registered slot contents
//  Revision : 1.0  initial release
// ============================================================================
module tx_burst_scheduler
    import tx_burst_scheduler_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BURST_MAX = c_BURST_MAX_DEF
) (
    input  logic                         USER_CLK,
    input  logic                         SYSTEM_RESET,
    input  logic [c_WORD_W*NUM_CH-1:0]   CH_DATA,
    input  logic [NUM_CH-1:0]            CH_VALID,
    input  logic [NUM_CH-1:0]            CH_EOP,
    input  logic [NUM_CH-1:0]            CH_ENABLE,
    output logic [NUM_CH-1:0]            CH_POP,
    input  logic                         TX_READY,
    output logic [c_WORD_W-1:0]          TX_DATA,
    output logic                         TX_VALID,
    output logic [ch_w(NUM_CH)-1:0]      TX_CHANNEL,
    output logic                         TX_SOB,
    output logic                         TX_EOB,
    output logic                         TX_EOP,
    output logic                         TX_ABORT
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    sched_state_t        r_state;
    logic [CH_W-1:0]     r_lock_ch;
    logic [CH_W-1:0]     r_last_grant;
    logic [CNT_W-1:0]    r_burst_cnt;

    logic [NUM_CH-1:0]   w_elig;
    logic [NUM_CH-1:0]   w_arb_grant;
    logic [CH_W-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic [CH_W-1:0]     w_sel_ch;
    logic                w_sel_ok;
    logic                w_sel_eop;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_eob;
    logic [c_WORD_W-1:0] w_ch_word [NUM_CH];

    assign w_elig = CH_VALID & CH_ENABLE;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_ch_word[gi] = CH_DATA[c_WORD_W*gi +: c_WORD_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req    (w_elig),
        .ptr    (r_last_grant),
        .grant  (w_arb_grant),
        .idx    (w_arb_idx),
        .any    (w_arb_any)
    );

    // While locked the arbiter result is ignored; only the lock channel may pop
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_sel_ch   = w_arb_idx;
            w_sel_ok   = w_arb_any;
            w_cnt_next = CNT_W'(1);
        end else begin
            w_sel_ch   = r_lock_ch;
            w_sel_ok   = w_elig[r_lock_ch];
            w_cnt_next = r_burst_cnt + CNT_W'(1);
        end
        w_sel_eop = CH_EOP[w_sel_ch];
        w_eob     = w_sel_eop || (w_cnt_next == CNT_W'(BURST_MAX));
    end

    always_comb begin
        CH_POP = '0;
        if (TX_READY && !SYSTEM_RESET && w_sel_ok) begin
            CH_POP[w_sel_ch] = 1'b1;
        end
    end

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            r_state      <= ST_IDLE;
            r_lock_ch    <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_burst_cnt  <= '0;
            TX_DATA      <= '0;
            TX_VALID     <= 1'b0;
            TX_CHANNEL   <= '0;
            TX_SOB       <= 1'b0;
            TX_EOB       <= 1'b0;
            TX_EOP       <= 1'b0;
            TX_ABORT     <= 1'b0;
        end else if (TX_READY) begin
            if (r_state == ST_BURST && !CH_ENABLE[r_lock_ch]) begin
                // Channel disabled under a lock: abandon the burst, no pop
                TX_VALID <= 1'b0;
                TX_SOB   <= 1'b0;
                TX_EOB   <= 1'b0;
                TX_EOP   <= 1'b0;
                TX_ABORT <= 1'b1;
                r_state  <= ST_IDLE;
            end else if (w_sel_ok) begin
                TX_DATA      <= w_ch_word[w_sel_ch];
                TX_VALID     <= 1'b1;
                TX_CHANNEL   <= w_sel_ch;
                TX_SOB       <= (r_state == ST_IDLE);
                TX_EOB       <= w_eob;
                TX_EOP       <= w_sel_eop;
                TX_ABORT     <= 1'b0;
                r_burst_cnt  <= w_cnt_next;
                r_lock_ch    <= w_sel_ch;
                r_last_grant <= w_sel_ch;
                r_state      <= w_eob ? ST_IDLE : ST_BURST;
            end else begin
                // Nothing eligible, or underrun under a lock: idle slot,
                // lock and count are kept
                TX_VALID <= 1'b0;
                TX_SOB   <= 1'b0;
                TX_EOB   <= 1'b0;
                TX_EOP   <= 1'b0;
                TX_ABORT <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_burst_scheduler
//  Purpose  : Directed self-checking bench for tx_burst_scheduler with
//             NUM_CH=4, BURST_MAX=8. Channel sources are modelled as
//             counters: word = {channel, 24'h0, head index}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_burst_scheduler;

    localparam int NUM_CH    = 4;
    localparam int BURST_MAX = 8;

    logic                    clk;
    logic                    rst;
    logic [64*NUM_CH-1:0]    ch_data;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0]       ch_eop;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_pop;
    logic                    tx_ready;
    logic [63:0]             tx_data;
    logic                    tx_valid;
    logic [1:0]              tx_channel;
    logic                    tx_sob;
    logic                    tx_eob;
    logic                    tx_eop;
    logic                    tx_abort;

    int head    [NUM_CH];   // words popped so far
    int pos     [NUM_CH];   // position inside current packet
    int pkt_len [NUM_CH];   // 0 = endless packet
    int avail   [NUM_CH];   // words available, -1 = endless

    int n_tests = 0;
    int n_fail  = 0;

    tx_burst_scheduler #(
        .NUM_CH    (NUM_CH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .USER_CLK     (clk),
        .SYSTEM_RESET (rst),
        .CH_DATA      (ch_data),
        .CH_VALID     (ch_valid),
        .CH_EOP       (ch_eop),
        .CH_ENABLE    (ch_enable),
        .CH_POP       (ch_pop),
        .TX_READY     (tx_ready),
        .TX_DATA      (tx_data),
        .TX_VALID     (tx_valid),
        .TX_CHANNEL   (tx_channel),
        .TX_SOB       (tx_sob),
        .TX_EOB       (tx_eob),
        .TX_EOP       (tx_eop),
        .TX_ABORT     (tx_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input int ch, input int h);
        return {8'(ch), 24'h0, 32'(h)};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[64*i +: 64] = word_of(i, head[i]);
            ch_valid[i]         = (avail[i] != 0);
            ch_eop[i]           = (pkt_len[i] != 0) && (pos[i] == pkt_len[i] - 1);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NUM_CH; i++) begin
            head[i]    = 0;
            pos[i]     = 0;
            pkt_len[i] = 0;
            avail[i]   = 0;
        end
        ch_enable = '1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        tx_ready = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One strobe with three quiet cycles ahead of it; returns the pop vector
    // seen in the strobe cycle and advances the source model accordingly.
    task automatic slot(output logic [NUM_CH-1:0] pop);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b1;
        #1 pop = ch_pop;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop[i]) begin
                head[i]++;
                pos[i]++;
                if (pkt_len[i] != 0 && pos[i] == pkt_len[i]) pos[i] = 0;
                if (avail[i] > 0) avail[i]--;
            end
        end
    endtask

    task automatic data_slot(input string tag, input int ch, input logic sob,
                             input logic eob, input logic eop);
        logic [NUM_CH-1:0] p;
        int h;
        h = head[ch];
        slot(p);
        check({tag, " pop"},   64'(p), 64'(1 << ch));
        check({tag, " valid"}, 64'(tx_valid), 64'd1);
        check({tag, " chan"},  64'(tx_channel), 64'(ch));
        check({tag, " flags"}, 64'({tx_sob, tx_eob, tx_eop, tx_abort}),
                               64'({sob, eob, eop, 1'b0}));
        check({tag, " data"},  tx_data, word_of(ch, h));
    endtask

    task automatic idle_slot(input string tag, input logic abort);
        logic [NUM_CH-1:0] p;
        slot(p);
        check({tag, " pop"},   64'(p), 64'd0);
        check({tag, " valid"}, 64'(tx_valid), 64'd0);
        check({tag, " flags"}, 64'({tx_sob, tx_eob, tx_eop, tx_abort}),
                               64'({3'b000, abort}));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " data"},  tx_data, 64'd0);
        check({tag, " ctl"},   64'({tx_valid, tx_channel, tx_sob, tx_eob, tx_eop, tx_abort}), 64'd0);
        check({tag, " pop"},   64'(ch_pop), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        rst      = 1'b1;
        tx_ready = 1'b0;
        clear_sources();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Four endless channels: bursts 0,1,2,3,0 of eight words each
        for (int i = 0; i < NUM_CH; i++) avail[i] = -1;
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < BURST_MAX; w++) begin
                data_slot($sformatf("rr b%0d w%0d", b, w), b % NUM_CH,
                          (w == 0), (w == BURST_MAX - 1), 1'b0);
            end
        end

        // Channel 2 alone with a three-word packet
        clear_sources();
        do_reset();
        pkt_len[2] = 3;
        avail[2]   = 3;
        data_slot("c2 w0", 2, 1'b1, 1'b0, 1'b0);
        data_slot("c2 w1", 2, 1'b0, 1'b0, 1'b0);
        data_slot("c2 w2", 2, 1'b0, 1'b1, 1'b1);
        held = tx_data;
        idle_slot("c2 idle", 1'b0);
        check("c2 idle hold", tx_data, held);

        // Underrun on channel 1 while channel 3 waits
        clear_sources();
        do_reset();
        avail[1] = 2;
        avail[3] = -1;
        data_slot("ur w0", 1, 1'b1, 1'b0, 1'b0);
        data_slot("ur w1", 1, 1'b0, 1'b0, 1'b0);
        idle_slot("ur gap0", 1'b0);
        idle_slot("ur gap1", 1'b0);
        avail[1] = -1;
        for (int w = 2; w < BURST_MAX; w++) begin
            data_slot($sformatf("ur w%0d", w), 1, 1'b0, (w == BURST_MAX - 1), 1'b0);
        end
        data_slot("ur next", 3, 1'b1, 1'b0, 1'b0);

        // Underrun then disable: abort slot, then channel 3 wins
        clear_sources();
        do_reset();
        avail[1] = 2;
        avail[3] = -1;
        data_slot("ab w0", 1, 1'b1, 1'b0, 1'b0);
        data_slot("ab w1", 1, 1'b0, 1'b0, 1'b0);
        idle_slot("ab gap", 1'b0);
        ch_enable[1] = 1'b0;
        idle_slot("ab abort", 1'b1);
        data_slot("ab next", 3, 1'b1, 1'b0, 1'b0);

        // Single-word packets on channels 0 and 3
        clear_sources();
        do_reset();
        pkt_len[0] = 1;  avail[0] = 1;
        pkt_len[3] = 1;  avail[3] = 1;
        data_slot("sw c0", 0, 1'b1, 1'b1, 1'b1);
        data_slot("sw c3", 3, 1'b1, 1'b1, 1'b1);

        // Reset mid-burst, with the strobe held high during reset
        clear_sources();
        do_reset();
        for (int i = 0; i < NUM_CH; i++) avail[i] = -1;
        data_slot("mr w0", 0, 1'b1, 1'b0, 1'b0);
        data_slot("mr w1", 0, 1'b0, 1'b0, 1'b0);
        data_slot("mr w2", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        tx_ready = 1'b1;
        #1 check_zero("mr async");
        @(negedge clk);
        check_zero("mr held");
        rst      = 1'b0;
        tx_ready = 1'b0;
        avail[0] = 0;
        data_slot("mr after", 1, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
